// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode decoder: parses E0/F0 prefixes, emits one event per key sequence
// and tracks the held state of four direction keys.
module ps2_key_tracker #(
    parameter logic [7:0] UP_CODE    = 8'h75,
    parameter logic [7:0] DOWN_CODE  = 8'h72,
    parameter logic [7:0] LEFT_CODE  = 8'h6B,
    parameter logic [7:0] RIGHT_CODE = 8'h74,
    parameter bit         MATCH_EXT  = 1'b1,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic [3:0] held,
    output logic [3:0] accel,
    output logic [3:0] turn
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic       emit;
    logic       emit_ext;
    logic       emit_brk;
    logic       is_prefix;
    logic       is_noise;
    logic       ext_ok;
    logic [3:0] hit;
    logic       timed_out;

    always_comb begin
        is_prefix = (ps2_data == 8'hE0) || (ps2_data == 8'hF0);
        is_noise  = (ps2_data == 8'hE1) || (ps2_data == 8'hAA) || (ps2_data == 8'hFA) ||
                    (ps2_data == 8'hFE) || (ps2_data == 8'hEE) || (ps2_data == 8'h00) ||
                    (ps2_data == 8'hFF);
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (ps2_valid) begin
            case (state)
                IDLE:    emit = !is_prefix && !is_noise;
                EXT:     emit = !is_prefix;
                BRK:     emit = !is_prefix;
                EXT_BRK: emit = !is_prefix;
                default: emit = 1'b0;
            endcase
            emit_ext = (state == EXT) || (state == EXT_BRK);
            emit_brk = (state == BRK) || (state == EXT_BRK);
        end
        ext_ok = emit_ext || !MATCH_EXT;
        hit    = {ps2_data == RIGHT_CODE, ps2_data == LEFT_CODE,
                  ps2_data == DOWN_CODE,  ps2_data == UP_CODE} & {4{ext_ok}};
        timed_out = (state != IDLE) && (timer == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state     <= IDLE;
            timer     <= '0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
            held      <= '0;
        end else begin
            key_valid <= emit;
            if (emit) begin
                key_code  <= ps2_data;
                key_ext   <= emit_ext;
                key_break <= emit_brk;
                held      <= emit_brk ? (held & ~hit) : (held | hit);
            end

            if (ps2_valid || state == IDLE || timed_out)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            // A byte arriving on the timeout cycle is still handled in the current state.
            if (ps2_valid) begin
                case (state)
                    IDLE: begin
                        if (ps2_data == 8'hE0)      state <= EXT;
                        else if (ps2_data == 8'hF0) state <= BRK;
                        else                        state <= IDLE;
                    end
                    EXT: begin
                        if (ps2_data == 8'hF0)      state <= EXT_BRK;
                        else if (ps2_data == 8'hE0) state <= EXT;
                        else                        state <= IDLE;
                    end
                    BRK:     state <= is_prefix ? BRK : IDLE;
                    EXT_BRK: state <= is_prefix ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end else if (timed_out) begin
                state <= IDLE;
            end
        end
    end

    always_comb begin
        accel = 4'h0;
        turn  = 4'h0;
        if (held[0] && !held[1]) accel = 4'h1;
        if (held[1] && !held[0]) accel = 4'h2;
        if (held[2] && !held[3]) turn  = 4'h1;
        if (held[3] && !held[2]) turn  = 4'h2;
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a strict-E0 instance and a prefix-agnostic instance
// share one byte stream; expected values are hand-computed.
module tb_ps2_key_tracker;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_valid = 1'b0;

    logic [7:0] key_code,  key_code2;
    logic       key_ext,   key_ext2;
    logic       key_break, key_break2;
    logic       key_valid, key_valid2;
    logic [3:0] held,  held2;
    logic [3:0] accel, accel2;
    logic [3:0] turn,  turn2;

    int unsigned tests  = 0;
    int unsigned errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker #(.MATCH_EXT(1'b1), .TIMEOUT(16)) u_dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
        .held(held), .accel(accel), .turn(turn)
    );

    ps2_key_tracker #(.MATCH_EXT(1'b0), .TIMEOUT(16)) u_noext (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_code(key_code2), .key_ext(key_ext2), .key_break(key_break2), .key_valid(key_valid2),
        .held(held2), .accel(accel2), .turn(turn2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the negedge after the byte's sampling edge, so outputs show its effect.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        ps2_data  = b;
        ps2_valid = 1'b1;
        @(negedge CLOCK_50);
        ps2_valid = 1'b0;
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic ext, input logic brk);
        check({tag, "_valid"}, key_valid, 1'b1);
        check({tag, "_code"},  key_code,  code);
        check({tag, "_ext"},   key_ext,   ext);
        check({tag, "_break"}, key_break, brk);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        check("rst_code",  key_code,  8'h00);
        check("rst_flags", {key_ext, key_break, key_valid}, 3'b000);
        check("rst_held",  held,  4'h0);
        check("rst_accel", accel, 4'h0);
        check("rst_turn",  turn,  4'h0);
        resetn = 1'b1;

        // 1: extended up make, then extended up break
        send_byte(8'hE0);
        check("t1_prefix_novalid", key_valid, 1'b0);
        send_byte(8'h75);
        expect_event("t1_make", 8'h75, 1'b1, 1'b0);
        check("t1_held", held, 4'b0001);
        check("t1_accel", accel, 4'h1);
        @(negedge CLOCK_50);
        check("t1_pulse_len", key_valid, 1'b0);
        check("t1_code_hold", key_code, 8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_event("t1_brk", 8'h75, 1'b1, 1'b1);
        check("t1_held_rel", held, 4'b0000);
        check("t1_accel_rel", accel, 4'h0);

        // 2: plain 75 ignores the direction in strict mode only
        send_byte(8'h75);
        expect_event("t2_make", 8'h75, 1'b0, 1'b0);
        check("t2_held", held, 4'b0000);
        check("t2_accel", accel, 4'h0);
        check("t2_held_noext", held2, 4'b0001);
        send_byte(8'hF0); send_byte(8'h75);
        expect_event("t2_brk_unheld", 8'h75, 1'b0, 1'b1);
        check("t2_held_after", held, 4'b0000);
        check("t2_held2_after", held2, 4'b0000);

        // 3: up+down cancel, releasing up leaves down
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h72);
        check("t3_held", held, 4'b0011);
        check("t3_accel", accel, 4'h0);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("t3_accel_down", accel, 4'h2);
        check("t3_held_down", held, 4'b0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        check("t3_held_clr", held, 4'b0000);

        // 4: left+right cancel; non-direction break leaves held alone
        send_byte(8'hE0); send_byte(8'h6B);
        check("t4_turn_left", turn, 4'h1);
        send_byte(8'hE0); send_byte(8'h74);
        check("t4_turn_both", turn, 4'h0);
        check("t4_held_both", held, 4'b1100);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check("t4_turn_after", turn, 4'h1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
        expect_event("t4_brk1c", 8'h1C, 1'b1, 1'b1);
        check("t4_held_same", held, 4'b0100);
        send_byte(8'hE0); send_byte(8'h6B);
        expect_event("t4_typematic", 8'h6B, 1'b1, 1'b0);
        check("t4_typematic_held", held, 4'b0100);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("t4_held_clr", held, 4'b0000);

        // Ignored byte produces no event
        send_byte(8'hAA);
        check("noise_novalid", key_valid, 1'b0);
        check("noise_code", key_code, 8'h6B);

        // Back-to-back bytes are all consumed
        @(negedge CLOCK_50);
        ps2_data = 8'hE0; ps2_valid = 1'b1;
        @(negedge CLOCK_50);
        ps2_data = 8'h74;
        @(negedge CLOCK_50);
        ps2_valid = 1'b0;
        expect_event("b2b_make", 8'h74, 1'b1, 1'b0);
        check("b2b_turn", turn, 4'h2);
        @(negedge CLOCK_50);
        ps2_data = 8'hE0; ps2_valid = 1'b1;
        @(negedge CLOCK_50);
        ps2_data = 8'hF0;
        @(negedge CLOCK_50);
        ps2_data = 8'h74;
        @(negedge CLOCK_50);
        ps2_valid = 1'b0;
        expect_event("b2b_brk", 8'h74, 1'b1, 1'b1);
        check("b2b_held", held, 4'b0000);

        // 5: 16 idle cycles after E0,F0 discard the prefixes
        send_byte(8'hE0); send_byte(8'hF0);
        repeat (15) @(negedge CLOCK_50);
        send_byte(8'h75);
        expect_event("t5_timeout", 8'h75, 1'b0, 1'b0);
        check("t5_held", held, 4'b0000);
        check("t5_held_noext", held2, 4'b0001);
        send_byte(8'hF0); send_byte(8'h75);
        check("t5_held2_clr", held2, 4'b0000);
        // Byte arriving on the timeout cycle still completes the sequence
        send_byte(8'hE0); send_byte(8'hF0);
        repeat (14) @(negedge CLOCK_50);
        send_byte(8'h75);
        expect_event("t5_byte_wins", 8'h75, 1'b1, 1'b1);

        // 6: reset mid-sequence drops the E0 prefix and clears held
        send_byte(8'hE0); send_byte(8'h75);
        check("t6_held_pre", held, 4'b0001);
        send_byte(8'hE0);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("t6_rst_valid", key_valid, 1'b0);
        check("t6_rst_held", held, 4'b0000);
        check("t6_rst_accel", accel, 4'h0);
        check("t6_rst_code", key_code, 8'h00);
        resetn = 1'b1;
        send_byte(8'h75);
        expect_event("t6_after", 8'h75, 1'b0, 1'b0);
        check("t6_held", held, 4'b0000);
        check("t6_held_noext", held2, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
